// File: rtl/pitch_tracker.sv
// pitch_tracker: two-stage pitch tracker for per-frame HPS peak bins.
// Stage 1 registers the filtered sample f; stage 2 runs a SEARCH/LOCKED FSM
// that qualifies a pitch after LOCK_COUNT consecutive matches and releases it
// after DROP_COUNT consecutive misses.
// Optional feature: define PITCH_TRACKER_MEDIAN_EN to replace the stage-1
// pass-through register with a 3-sample median filter.
module pitch_tracker #(
    parameter int unsigned K_WIDTH    = 12,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned DROP_COUNT = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [K_WIDTH-1:0] k_max,
    input  logic               k_max_valid,
    output logic [K_WIDTH-1:0] pitch_k,
    output logic               pitch_valid,
    output logic               pitch_locked
);

    localparam int unsigned CNT_TOP = (LOCK_COUNT > DROP_COUNT) ? LOCK_COUNT : DROP_COUNT;
    localparam int unsigned CW      = (CNT_TOP < 1) ? 1 : $clog2(CNT_TOP + 1);
    localparam int unsigned DW      = K_WIDTH + 1;

    localparam logic [DW-1:0] TOL_D   = DW'(TOL);
    localparam logic [CW-1:0] LOCK_C  = CW'(LOCK_COUNT);
    localparam logic [CW-1:0] DROP_C  = CW'(DROP_COUNT);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    // Stage-1 output: filtered sample and its qualifier
    logic               s1_valid;
    logic [K_WIDTH-1:0] s1_f;

`ifdef PITCH_TRACKER_MEDIAN_EN
    // Two stored samples plus the incoming one form the 3-deep window
    logic [K_WIDTH-1:0] hist0;
    logic [K_WIDTH-1:0] hist1;
    logic [1:0]         hist_cnt;

    function automatic logic [K_WIDTH-1:0] median3(input logic [K_WIDTH-1:0] a,
                                                   input logic [K_WIDTH-1:0] b,
                                                   input logic [K_WIDTH-1:0] c);
        logic [K_WIDTH-1:0] lo;
        logic [K_WIDTH-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c <= lo) begin
            return lo;
        end else if (c >= hi) begin
            return hi;
        end
        return c;
    endfunction

    // Shift history and register the median once three samples are present
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist0    <= '0;
            hist1    <= '0;
            hist_cnt <= '0;
            s1_valid <= 1'b0;
            s1_f     <= '0;
        end else begin
            s1_valid <= k_max_valid && (hist_cnt == 2'd2);
            if (k_max_valid) begin
                hist1 <= hist0;
                hist0 <= k_max;
                if (hist_cnt != 2'd2) begin
                    hist_cnt <= hist_cnt + 2'd1;
                end
                s1_f <= median3(k_max, hist0, hist1);
            end
        end
    end
`else
    // Pass-through register keeps the same two-cycle latency as the median path
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
        end else begin
            s1_valid <= k_max_valid;
            if (k_max_valid) begin
                s1_f <= k_max;
            end
        end
    end
`endif

    state_e             state;
    logic [K_WIDTH-1:0] candidate;
    logic [CW-1:0]      match_cnt;
    logic [CW-1:0]      miss_cnt;

    // Distance is taken one bit wider than the bins so it can never wrap
    function automatic logic [DW-1:0] abs_diff(input logic [K_WIDTH-1:0] a,
                                               input logic [K_WIDTH-1:0] b);
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    logic          voiced;
    logic          cand_match;
    logic          pitch_match;
    logic [CW-1:0] match_next;
    logic [CW-1:0] miss_inc;

    // Match decisions and saturating counter next values for the FSM
    always_comb begin
        voiced      = (s1_f != '0);
        // match_cnt == 0 means there is no candidate to compare against
        cand_match  = voiced && (match_cnt != '0) && (abs_diff(s1_f, candidate) <= TOL_D);
        pitch_match = voiced && (abs_diff(s1_f, pitch_k) <= TOL_D);
        match_next  = '0;
        if (cand_match) begin
            match_next = (match_cnt == CNT_SAT) ? match_cnt : match_cnt + ONE_C;
        end else if (voiced) begin
            match_next = ONE_C;
        end
        miss_inc = (miss_cnt == CNT_SAT) ? miss_cnt : miss_cnt + ONE_C;
    end

    // Tracking FSM with registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StSearch;
            candidate    <= '0;
            match_cnt    <= '0;
            miss_cnt     <= '0;
            pitch_k      <= '0;
            pitch_valid  <= 1'b0;
            pitch_locked <= 1'b0;
        end else begin
            pitch_valid <= 1'b0;
            if (s1_valid) begin
                unique case (state)
                    StSearch: begin
                        match_cnt <= match_next;
                        // Unvoiced clears candidate because s1_f is zero
                        if (!cand_match) begin
                            candidate <= s1_f;
                        end
                        if (voiced && (match_next >= LOCK_C)) begin
                            state        <= StLocked;
                            pitch_locked <= 1'b1;
                            pitch_k      <= s1_f;
                            pitch_valid  <= 1'b1;
                            miss_cnt     <= '0;
                        end
                    end
                    StLocked: begin
                        if (pitch_match) begin
                            pitch_k     <= s1_f;
                            pitch_valid <= 1'b1;
                            miss_cnt    <= '0;
                        end else begin
                            miss_cnt <= miss_inc;
                            if (miss_inc >= DROP_C) begin
                                // pitch_k keeps the last locked value
                                state        <= StSearch;
                                pitch_locked <= 1'b0;
                                candidate    <= s1_f;
                                match_cnt    <= voiced ? ONE_C : '0;
                            end
                        end
                    end
                    default: begin
                        state        <= StSearch;
                        pitch_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pitch_tracker.md
PITCH_TRACKER -- requirements
Module: pitch_tracker

Interface
REQ-001 SHALL have parameter K_WIDTH, default 12, meaning bin-index width (4096-point FFT).
REQ-002 SHALL have parameter TOL, default 2, meaning max bin distance counted as "same pitch".
REQ-003 SHALL have parameter LOCK_COUNT, default 3, meaning consecutive matching frames needed to lock.
REQ-004 SHALL have parameter DROP_COUNT, default 4, meaning consecutive missed frames needed to unlock.
REQ-005 SHALL have port clock, input, 1, meaning sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port k_max, input, K_WIDTH, meaning per-frame HPS peak bin.
REQ-008 SHALL have port k_max_valid, input, 1, meaning single-cycle qualifier for k_max.
REQ-009 SHALL have port pitch_k, output, K_WIDTH, meaning tracked pitch bin.
REQ-010 SHALL have port pitch_valid, output, 1, meaning single-cycle pulse when pitch_k is updated.
REQ-011 SHALL have port pitch_locked, output, 1, meaning level, high while FSM is in LOCKED.

Function
REQ-012 SHALL use a 2-stage pipeline: stage 1 filter registered at cycle N+1 and FSM decision at cycle N+2, for k_max_valid at cycle N; pitch_valid SHALL pulse at N+2.
REQ-013 SHALL accept k_max_valid on back-to-back cycles with no stall and no dropped samples.
REQ-014 SHALL form the filtered sample f from the stage-1 register (median or pass-through per REQ-027/028).
REQ-015 SHALL compute |f - ref| at K_WIDTH+1 bits unsigned-magnitude, with no wrap-around; match means |f - ref| <= TOL.
REQ-016 SHALL treat f == 0 as unvoiced and never a match.
REQ-017 SHALL implement FSM states SEARCH (reset state) and LOCKED.
REQ-018 In SEARCH on a voiced match to candidate: match_cnt++; when match_cnt reaches LOCK_COUNT -> LOCKED, pitch_k <= f, pitch_valid pulse, miss_cnt <= 0.
REQ-019 In SEARCH on a voiced non-match: candidate <= f, match_cnt <= 1; on unvoiced: match_cnt <= 0, candidate <= 0.
REQ-020 In LOCKED on a match to pitch_k: pitch_k <= f, pitch_valid pulse, miss_cnt <= 0.
REQ-021 In LOCKED on a non-match or unvoiced: pitch_k held, no pulse, miss_cnt++; at miss_cnt == DROP_COUNT -> SEARCH, candidate <= f, match_cnt <= (f != 0).
REQ-022 pitch_locked SHALL deassert in the same cycle the FSM enters SEARCH; pitch_k SHALL retain its last locked value.
REQ-023 SHALL saturate match_cnt and miss_cnt, never wrapping.
REQ-024 With LOCK_COUNT == 1, the first voiced sample SHALL lock immediately.

Reset
REQ-025 While reset_n is low: state SEARCH; pitch_k, candidate, counters, and median history 0; pitch_valid 0; pitch_locked 0.
REQ-026 Reset asserted mid-pipeline SHALL discard all in-flight samples; the first k_max_valid after release SHALL be treated as history entry 1.

Configuration
REQ-027 With PITCH_TRACKER_MEDIAN_EN defined, stage 1 SHALL hold a 3-deep history and f SHALL be the median of the last three samples; no f SHALL be produced until three samples have been received since reset.
REQ-028 Without PITCH_TRACKER_MEDIAN_EN, f SHALL be k_max registered once, with identical 2-cycle latency and no history.

Verification
REQ-029 No macro, TOL=2: k_max 100, 101, 99 at cycles 0, 10, 20 -> pitch_locked rises and pitch_valid pulses at cycle 22 with pitch_k=99.
REQ-030 Locked at 99, then 300, 300, 300, 300 -> pitch_k stays 99; pitch_locked falls after the 4th sample; candidate=300, match_cnt=1.
REQ-031 Locked, then 0, 99 -> first sample is a miss, second is a match; pitch_valid pulses once; miss_cnt returns to 0.
REQ-032 Macro on: 100, 500, 100, 100, 100 -> medians 100, 100, 100; lock occurs on the 5th input; no pitch_valid before the 3rd input.
REQ-033 Back-to-back k_max_valid for 4 cycles at 50 -> lock pulse exactly 2 cycles after the 3rd sample, then a second pulse on the next cycle.
REQ-034 reset_n low for 1 cycle one cycle after k_max_valid -> no pitch_valid; all outputs 0; subsequent lock requires LOCK_COUNT fresh samples.
